// File: rtl/exhaustive_vector_sequencer.sv
// rtl/exhaustive_vector_sequencer.sv - exhaustive input-vector sweeper with record stream and MISR signature
module exhaustive_vector_sequencer #(
  parameter int N_IN   = 4,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_out,
  input  logic [OUT_W-1:0] dut_resp,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_IN-1:0]  rec_vec,
  output logic [OUT_W-1:0] rec_resp,
  output logic [SIG_W-1:0] signature,
  output logic             busy,
  output logic             done
);

  localparam int N_VEC = 1 << N_IN;
  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  // Index carries one spare bit so the last vector never aliases with 0.
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(N_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [N_IN:0]    index;
  logic [CNT_W-1:0] settle_cnt;
  logic [SIG_W-1:0] sig_next;

  // Next MISR value: shift with polynomial feedback, fold in the zero-extended (vector, response) pair.
  always_comb begin
    sig_next = {signature[SIG_W-2:0], 1'b0}
             ^ (signature[SIG_W-1] ? POLY : '0)
             ^ SIG_W'({vec_out, dut_resp});
  end

  // Sweep FSM with registered outputs; abort preempts every state, including a pending handshake.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      index      <= '0;
      settle_cnt <= '0;
      vec_out    <= '0;
      rec_vec    <= '0;
      rec_resp   <= '0;
      signature  <= '0;
      rec_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      rec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            signature <= '0;
            index     <= '0;
            busy      <= 1'b1;
            state     <= S_APPLY;
          end
        end
        S_APPLY: begin
          vec_out    <= index[N_IN-1:0];
          settle_cnt <= CNT_W'(SETTLE);
          state      <= (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt <= CNT_W'(1)) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          rec_resp  <= dut_resp;
          rec_vec   <= vec_out;
          signature <= sig_next;
          rec_valid <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          if (rec_ready) begin
            rec_valid <= 1'b0;
            if (index == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              index <= index + 1'b1;
              state <= S_APPLY;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// tb/tb_exhaustive_vector_sequencer.sv - directed bench for exhaustive_vector_sequencer
module tb_exhaustive_vector_sequencer;

  logic CK = 1'b0;
  logic reset = 1'b1;
  always #5 CK = ~CK;

  // Instance a: N_IN=2, SETTLE=1, response driven by the bench
  logic start_a = 0, abort_a = 0, resp_a = 0, ready_a = 0;
  logic [1:0] vec_a, rvec_a;
  logic rresp_a, rvalid_a, busy_a, done_a;
  logic [15:0] sig_a;

  // Instance b: N_IN=4, SETTLE=0, response = XOR of inputs
  logic start_b = 0, abort_b = 0, ready_b = 0;
  logic [3:0] vec_b, rvec_b;
  logic resp_b, rresp_b, rvalid_b, busy_b, done_b;
  logic [15:0] sig_b;
  assign resp_b = ^vec_b;

  // Instance c: N_IN=4, SETTLE=3, response = XOR of inputs
  logic start_c = 0, abort_c = 0, ready_c = 0;
  logic [3:0] vec_c, rvec_c;
  logic resp_c, rresp_c, rvalid_c, busy_c, done_c;
  logic [15:0] sig_c;
  assign resp_c = ^vec_c;

  exhaustive_vector_sequencer #(.N_IN(2), .OUT_W(1), .SETTLE(1), .SIG_W(16), .POLY(16'h1021)) u_a (
    .CK(CK), .reset(reset), .start(start_a), .abort(abort_a), .vec_out(vec_a), .dut_resp(resp_a),
    .rec_valid(rvalid_a), .rec_ready(ready_a), .rec_vec(rvec_a), .rec_resp(rresp_a),
    .signature(sig_a), .busy(busy_a), .done(done_a));

  exhaustive_vector_sequencer #(.N_IN(4), .OUT_W(1), .SETTLE(0), .SIG_W(16), .POLY(16'h1021)) u_b (
    .CK(CK), .reset(reset), .start(start_b), .abort(abort_b), .vec_out(vec_b), .dut_resp(resp_b),
    .rec_valid(rvalid_b), .rec_ready(ready_b), .rec_vec(rvec_b), .rec_resp(rresp_b),
    .signature(sig_b), .busy(busy_b), .done(done_b));

  exhaustive_vector_sequencer #(.N_IN(4), .OUT_W(1), .SETTLE(3), .SIG_W(16), .POLY(16'h1021)) u_c (
    .CK(CK), .reset(reset), .start(start_c), .abort(abort_c), .vec_out(vec_c), .dut_resp(resp_c),
    .rec_valid(rvalid_c), .rec_ready(ready_c), .rec_vec(rvec_c), .rec_resp(rresp_c),
    .signature(sig_c), .busy(busy_c), .done(done_c));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] v, input logic r);
    return (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'b0, v, r};
  endfunction

  // Full sweep on instance a with rec_ready=1; optional start pulse while busy
  task automatic sweep_a(input logic r, input logic [15:0] exp_sig, input logic poke);
    resp_a = r; ready_a = 1'b1; start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    check("a_busy_after_start", busy_a, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CK);
      start_a = poke && (k == 5);
      if (k % 4 == 3) begin
        check("a_rec_valid", rvalid_a, 1);
        check("a_rec_vec", rvec_a, k / 4);
        check("a_rec_resp", rresp_a, r);
      end
      if (k == 16) begin
        check("a_done_edge16", done_a, 1);
        check("a_signature", sig_a, exp_sig);
        check("a_busy_in_done", busy_a, 0);
      end else if (k == 15) begin
        check("a_done_early", done_a, 0);
      end
    end
    @(negedge CK);
    check("a_done_one_cycle", done_a, 0);
    check("a_signature_held", sig_a, exp_sig);
  endtask

  initial begin
    int n;
    logic [4:0] idx;
    logic [15:0] sig_m;
    logic stalled;
    logic seen;

    // Reset values
    repeat (2) @(negedge CK);
    check("rst_vec_out", vec_a, 0);
    check("rst_rec_valid", rvalid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_signature", sig_a, 0);
    check("rst_rec_vec", rvec_a, 0);
    check("rst_rec_resp", rresp_a, 0);
    check("rst_sig_b", sig_b, 0);
    reset = 1'b0;
    @(negedge CK);

    // T1 / T2: N_IN=2 sweeps, T1 also pulses start while busy
    sweep_a(1'b0, 16'h0006, 1'b1);
    sweep_a(1'b1, 16'h0009, 1'b0);

    // abort and start together in IDLE: stay IDLE
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0; abort_a = 1'b0;
    check("abort_start_idle_busy", busy_a, 0);
    @(negedge CK);
    check("abort_start_idle_busy2", busy_a, 0);
    check("abort_start_idle_sig", sig_a, 16'h0009);

    // T6: async reset while vector 2 is settling
    resp_a = 1'b0; start_a = 1'b1;
    @(negedge CK);
    start_a = 1'b0;
    repeat (9) @(negedge CK);
    check("t6_pre_vec", vec_a, 2);
    check("t6_pre_sig", sig_a, 16'h0002);
    check("t6_pre_busy", busy_a, 1);
    reset = 1'b1;
    #1;
    check("t6_vec_out", vec_a, 0);
    check("t6_signature", sig_a, 0);
    check("t6_rec_vec", rvec_a, 0);
    check("t6_busy", busy_a, 0);
    check("t6_rec_valid", rvalid_a, 0);
    check("t6_done", done_a, 0);
    @(negedge CK);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge CK);
      if (done_a || rvalid_a || busy_a) seen = 1'b1;
    end
    check("t6_quiet_after_reset", seen, 0);

    // T4: SETTLE=0 period 3 on instance b
    ready_b = 1'b1; start_b = 1'b1;
    @(negedge CK);
    start_b = 1'b0;
    n = 0; idx = 0;
    while (!done_b && n < 400) begin
      @(negedge CK);
      n++;
      if (rvalid_b) begin
        check("t4b_rec_vec", rvec_b, idx[3:0]);
        check("t4b_rec_resp", rresp_b, ^idx[3:0]);
        idx++;
      end
    end
    check("t4b_done_edge", n, 48);
    check("t4b_records", idx, 16);

    // T4: SETTLE=3 period 6 on instance c
    ready_c = 1'b1; start_c = 1'b1;
    @(negedge CK);
    start_c = 1'b0;
    n = 0; idx = 0;
    while (!done_c && n < 400) begin
      @(negedge CK);
      n++;
      if (rvalid_c) begin
        check("t4c_rec_vec", rvec_c, idx[3:0]);
        check("t4c_rec_resp", rresp_c, ^idx[3:0]);
        idx++;
      end
    end
    check("t4c_done_edge", n, 96);
    check("t4c_records", idx, 16);

    // T3: random backpressure on instance b
    ready_b = 1'b0; start_b = 1'b1;
    @(negedge CK);
    start_b = 1'b0;
    n = 0; idx = 0; sig_m = 16'h0; stalled = 1'b0;
    while (!done_b && n < 2000) begin
      @(negedge CK);
      n++;
      if (stalled) begin
        check("t3_valid_held", rvalid_b, 1);
        check("t3_vec_out_held", vec_b, idx[3:0]);
      end
      if (rvalid_b) begin
        check("t3_rec_vec", rvec_b, idx[3:0]);
        check("t3_rec_resp", rresp_b, ^idx[3:0]);
      end
      ready_b = 1'($urandom_range(0, 1));
      if (rvalid_b && ready_b) begin
        sig_m = misr(sig_m, idx[3:0], ^idx[3:0]);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = rvalid_b;
      end
    end
    check("t3_done", done_b, 1);
    check("t3_records", idx, 16);
    check("t3_signature", sig_b, sig_m);
    ready_b = 1'b1;
    @(negedge CK);

    // T5: abort while vector 5 is in EMIT
    ready_b = 1'b1; start_b = 1'b1;
    @(negedge CK);
    start_b = 1'b0;
    n = 0; idx = 0; sig_m = 16'h0;
    while (n < 200) begin
      @(negedge CK);
      n++;
      if (rvalid_b) begin
        check("t5_rec_vec", rvec_b, idx[3:0]);
        sig_m = misr(sig_m, idx[3:0], ^idx[3:0]);
        if (idx == 5) break;
        idx++;
      end
    end
    check("t5_reached_vec5", idx, 5);
    ready_b = 1'b0; abort_b = 1'b1;
    @(negedge CK);
    abort_b = 1'b0;
    check("t5_rec_valid", rvalid_b, 0);
    check("t5_busy", busy_b, 0);
    check("t5_done", done_b, 0);
    check("t5_partial_sig", sig_b, sig_m);
    seen = 1'b0;
    repeat (10) begin
      @(negedge CK);
      if (done_b || rvalid_b || busy_b) seen = 1'b1;
    end
    check("t5_no_done_after_abort", seen, 0);
    ready_b = 1'b1; start_b = 1'b1;
    @(negedge CK);
    start_b = 1'b0;
    check("t5_restart_sig_cleared", sig_b, 0);
    check("t5_restart_busy", busy_b, 1);
    repeat (2) @(negedge CK);
    check("t5_restart_valid", rvalid_b, 1);
    check("t5_restart_vec0", rvec_b, 0);
    n = 0;
    while (!done_b && n < 400) begin
      @(negedge CK);
      n++;
    end
    check("t5_restart_done", done_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
